// File: rtl/mcac_pkg.sv
// Shared definitions for the ADPCM float datapath: widths, float field layout
// and the float encoding of zero.
package mcac_pkg;
  localparam int FLT_W    = 11;
  localparam int SR_W     = 16;
  localparam int SIGN_BIT = 10;
  localparam int EXP_MSB  = 9;
  localparam int EXP_LSB  = 6;

  localparam logic [FLT_W-1:0] FLT_ZERO = 11'h020;

  typedef logic [FLT_W-1:0] flt_t;
endpackage

// File: rtl/sr_float_sched_floatb.sv
// FLOATB: 16-bit two's-complement to {sign, exp[3:0], mant[5:0]} float.
// Purely combinational so one instance can be time-shared.
module floatb
  import mcac_pkg::*;
(
  input  logic [SR_W-1:0] sr,
  output flt_t            flt
);

  logic [SR_W-1:0] neg;
  logic [14:0]     mag;
  logic [3:0]      exp;
  logic [20:0]     shifted;

  always_comb begin
    neg = -sr;
    // 16'h8000 negates to itself, so its 15-bit magnitude is 0 (float 11'h420).
    mag = sr[SR_W-1] ? neg[14:0] : sr[14:0];
    exp = '0;
    for (int i = 0; i < 15; i++) begin
      if (mag[i]) exp = 4'(i + 1);
    end
    shifted = {mag, 6'b0} >> exp;
    flt = '0;
    flt[SIGN_BIT]        = sr[SR_W-1];
    flt[EXP_MSB:EXP_LSB] = exp;
    flt[EXP_LSB-1:0]     = (mag == '0) ? 6'b100000 : shifted[5:0];
  end

endmodule

// File: rtl/sr_float_sched_rr_arbiter.sv
// Rotating-priority arbiter: grants the first requester at or above ptr,
// wrapping around; one-hot grant plus its index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/sr_float_sched.sv
// Shares one FLOATB converter among NCH SR producers (round robin) and keeps
// each channel's SR1/SR2 float delay line for the pole predictor.
module sr_float_sched
  import mcac_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH*SR_W-1:0]   req_sr,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH-1:0]        clr,
  output logic [NCH*FLT_W-1:0]  sr1,
  output logic [NCH*FLT_W-1:0]  sr2,
  output logic                  upd_valid,
  output logic [CHW-1:0]        upd_ch
);

  // Handshake: a sample transfers on the rising edge where req_valid[i] and
  // req_ready[i] are both high; req_ready is one-hot or zero, so at most one
  // transfer per cycle. A channel being cleared is never granted.
  logic [NCH-1:0]  eligible;
  logic [NCH-1:0]  grant;
  logic [CHW-1:0]  g_idx;
  logic            g_any;
  logic [CHW-1:0]  rr_ptr;
  logic [SR_W-1:0] g_sr;
  flt_t            g_flt;

  logic            s1_valid;
  logic [CHW-1:0]  s1_ch;
  flt_t            s1_flt;

  flt_t sr1_q [NCH];
  flt_t sr2_q [NCH];

  assign eligible  = req_valid & ~clr;
  assign req_ready = grant;
  assign g_sr      = req_sr[g_idx*SR_W +: SR_W];

  rr_arbiter #(.N(NCH), .IW(CHW)) u_arb (
    .req   (eligible),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  floatb u_floatb (
    .sr  (g_sr),
    .flt (g_flt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_flt   <= FLT_ZERO;
    end else begin
      s1_valid <= g_any;
      if (g_any) begin
        s1_ch  <= g_idx;
        s1_flt <= g_flt;
        rr_ptr <= (g_idx == CHW'(NCH - 1)) ? '0 : g_idx + 1'b1;
      end
    end
  end

  // A clear on the channel whose update is in flight wins over the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        sr1_q[i] <= FLT_ZERO;
        sr2_q[i] <= FLT_ZERO;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          sr1_q[i] <= FLT_ZERO;
          sr2_q[i] <= FLT_ZERO;
        end else if (s1_valid && s1_ch == CHW'(i)) begin
          sr2_q[i] <= sr1_q[i];
          sr1_q[i] <= s1_flt;
        end
      end
    end
  end

  always_comb begin
    sr1 = '0;
    sr2 = '0;
    for (int i = 0; i < NCH; i++) begin
      sr1[i*FLT_W +: FLT_W] = sr1_q[i];
      sr2[i*FLT_W +: FLT_W] = sr2_q[i];
    end
  end

  assign upd_valid = s1_valid;
  assign upd_ch    = s1_ch;

endmodule

// File: doc/sr_float_sched.md
Name: sr_float_sched

Overview:
- Time-shares one 16-bit two's-complement to 11-bit float converter (FLOATB) among NCH ADPCM channel requesters.
- Round-robin arbitration with a valid/ready handshake per channel.
- Maintains each channel's SR1/SR2 float delay line, which feeds the pole predictor.
- Sits between the per-channel reconstructed-signal (SR) producers and the predictor tap storage.

Parameters:
- NCH, 4, number of channels sharing the converter (2..8).
- CHW, 2, channel index width; equals ceil(log2(NCH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NCH  channel i has an SR sample pending.
- req_sr  in  NCH*16  channel i SR sample, two's complement, slice [16i+15:16i].
- req_ready  out  NCH  one-hot grant; the sample is accepted when req_valid[i] and req_ready[i] are both high.
- clr  in  NCH  per-channel synchronous reinitialise of the delay line.
- sr1  out  NCH*11  per-channel SR1, the float of the last accepted sample.
- sr2  out  NCH*11  per-channel SR2, the float of the sample before SR1.
- upd_valid  out  1  one-cycle pulse: the delay line of upd_ch was updated.
- upd_ch  out  CHW  channel updated this cycle.

Behaviour:
- Reset (async, high):
  - Every sr1/sr2 entry = 11'h020 (float of zero: sign 0, exp 0, mant 100000).
  - upd_valid = 0, upd_ch = 0, rr pointer = 0, stage-1 registers cleared.
- Arbitration (combinational):
  - Eligible channels: req_valid[i] & ~clr[i].
  - Grant the first eligible channel searching from rr pointer upward, with wrap.
  - req_ready = one-hot grant; all zero if none eligible.
  - At most one accept per cycle.
- rr pointer: after an accept on channel g, pointer = (g+1) mod NCH; otherwise unchanged.
- Pipeline:
  - Cycle N (accept): register grant index and the FLOATB output, converting the granted sample.
  - Cycle N+1: sr2[g] <= sr1[g]; sr1[g] <= new float; upd_valid = 1; upd_ch = g.
  - Latency is 1 clock from accept to visible update. Throughput is 1 sample/cycle.
- Back-to-back accepts on the same channel (NCH=1, or only one requester):
  - Each update shifts correctly.
  - No forwarding is needed, because the write happens in one register stage.
- clr[i]:
  - Next edge: sr1[i] = sr2[i] = 11'h020.
  - clr[i] also masks the channel's request that cycle (req_ready[i] = 0).
- Pending update vs clear on the same channel: if a stage-1 update for channel i is pending in the same cycle clr[i] is high, clr wins. The delay line is zeroed and upd_valid is still pulsed with upd_ch = i.
- Requester rules: req_sr must stay stable while req_valid is high and not yet accepted. The block does not check this.
- Float format is {sign, exp[3:0], mant[5:0]}:
  - MAG = |SR| truncated to 15 bits.
  - exp = bit position of the MSB of MAG, plus 1 (0 when MAG = 0).
  - mant = normalised top 6 bits, forced to 100000 when MAG = 0.
  - SR = 16'h8000 gives MAG 0, so float 11'h420; this is a documented corner that must be preserved.
- Reset mid-operation: the in-flight stage-1 result is discarded and no upd_valid is emitted.

Decomposition:
- Shared package mcac_pkg:
  - FLT_W = 11, SR_W = 16.
  - FLT_ZERO = 11'h020.
  - Float field offsets (SIGN_BIT = 10, EXP_MSB = 9, EXP_LSB = 6).
- Sub-module: one instance of FLOATB as the shared combinational converter.
- A small rr_arbiter sub-module (NCH-wide, rotating priority) is natural and reusable for the FLOATA sharing block.

Test Plan:
- Reset: assert reset mid-stream -> all sr1/sr2 = 11'h020, upd_valid = 0, no update from the in-flight sample.
- Single channel: ch0 sends 16'h0001 then 16'h0005 -> sr1[0] = 11'h060 then 11'h0E8, sr2[0] = 11'h060; upd_valid one cycle after each accept.
- Sign and corners on ch1:
  - 16'hFFFF -> 11'h460.
  - 16'h4000 -> 11'h3E0.
  - 16'h8000 -> 11'h420.
  - 16'h0000 -> 11'h020.
- Round robin: all 4 channels hold valid continuously from pointer 0 -> grant order 0,1,2,3,0; each req_ready one-hot; upd_ch follows the grant order one cycle later.
- Clear priority: clr[2] and req_valid[2] high in the same cycle, with only ch2 requesting -> req_ready = 0; sr1[2] = sr2[2] = 11'h020; the sample is accepted the next cycle after clr drops.
- Hold stability: ch3 valid while ch0..ch2 win -> ch3 is granted within NCH cycles, and its accepted value matches the held req_sr.
